// File: rtl/simple_core_pkg.sv
// Shared definitions for the simple_core_mc multi-cycle core: opcodes, FSM
// states and instruction field extraction for any register-address width.
package simple_core_pkg;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_HALT  = 2'b11;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_HALT
    } state_e;

    // Widest instruction word / register field the helpers can slice.
    localparam int unsigned INSTR_MAX_W = 32;
    localparam int unsigned FIELD_MAX_W = 8;

    function automatic logic [1:0] instr_op(input logic [INSTR_MAX_W-1:0] instr,
                                            input int unsigned            reg_aw);
        logic [INSTR_MAX_W-1:0] sh;
        sh = instr >> (3 * reg_aw);
        return sh[1:0];
    endfunction

    // slot 2 = rd, slot 1 = rs1, slot 0 = rs2
    function automatic logic [FIELD_MAX_W-1:0] instr_field(input logic [INSTR_MAX_W-1:0] instr,
                                                           input int unsigned            reg_aw,
                                                           input int unsigned            slot);
        logic [INSTR_MAX_W-1:0] sh;
        logic [INSTR_MAX_W-1:0] mask;
        sh   = instr >> (slot * reg_aw);
        mask = (INSTR_MAX_W'(1) << reg_aw) - INSTR_MAX_W'(1);
        sh   = sh & mask;
        return sh[FIELD_MAX_W-1:0];
    endfunction

    function automatic logic [FIELD_MAX_W-1:0] instr_rd(input logic [INSTR_MAX_W-1:0] instr,
                                                        input int unsigned            reg_aw);
        return instr_field(instr, reg_aw, 2);
    endfunction

    function automatic logic [FIELD_MAX_W-1:0] instr_rs1(input logic [INSTR_MAX_W-1:0] instr,
                                                         input int unsigned            reg_aw);
        return instr_field(instr, reg_aw, 1);
    endfunction

    function automatic logic [FIELD_MAX_W-1:0] instr_rs2(input logic [INSTR_MAX_W-1:0] instr,
                                                         input int unsigned            reg_aw);
        return instr_field(instr, reg_aw, 0);
    endfunction

endpackage

// File: rtl/simple_core_regfile.sv
// NREG x DATA_W register file: two combinational read ports, one synchronous
// write port; a write lands at the clock edge, so same-cycle reads see old data.
module simple_core_regfile #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_addr_i,
    input  logic [REG_AW-1:0] rs2_addr_i,
    output logic [DATA_W-1:0] rs1_data_o,
    output logic [DATA_W-1:0] rs2_data_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    localparam int NREG = 2 ** REG_AW;

    logic [DATA_W-1:0] regs_q [NREG];

    // NOTE: this array is architectural state that must read as zero after reset,
    // so it is reset in full; that keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rs1_data_o = regs_q[rs1_addr_i];
    assign rs2_data_o = regs_q[rs2_addr_i];

endmodule

// File: rtl/simple_core_mc.sv
// Multi-cycle SimpleCPU core: FETCH/EXEC/MEM/HALT FSM, PC and ALU, with
// req/valid instruction fetch and req/ready data access.
module simple_core_mc
    import simple_core_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int REG_AW   = 2,
    parameter int PC_W     = 4,
    parameter int PROG_LEN = 6,
    parameter int DMEM_AW  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [PC_W-1:0]       imem_addr,
    input  logic [2+3*REG_AW-1:0] imem_rdata,
    input  logic                  imem_valid,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DMEM_AW-1:0]    dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic [DATA_W-1:0]     dmem_rdata,
    input  logic                  dmem_ready,
    output logic [PC_W-1:0]       pc,
    output logic                  carry,
    output logic                  halted
);

    localparam int IW = 2 + 3 * REG_AW;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [IW-1:0]     ir_q, ir_d;
    logic              carry_q, carry_d;
    logic              boot_q;

    logic [1:0]        op;
    logic [REG_AW-1:0] rd_idx, rs1_idx, rs2_idx;
    logic [DATA_W-1:0] rs1_data, rs2_data;
    logic [DATA_W:0]   sum;
    logic [PC_W-1:0]   pc_adv;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;

    assign op      = instr_op(INSTR_MAX_W'(ir_q), REG_AW);
    assign rd_idx  = REG_AW'(instr_rd(INSTR_MAX_W'(ir_q), REG_AW));
    assign rs1_idx = REG_AW'(instr_rs1(INSTR_MAX_W'(ir_q), REG_AW));
    assign rs2_idx = REG_AW'(instr_rs2(INSTR_MAX_W'(ir_q), REG_AW));

    simple_core_regfile #(
        .DATA_W(DATA_W),
        .REG_AW(REG_AW)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rs1_addr_i(rs1_idx),
        .rs2_addr_i(rs2_idx),
        .rs1_data_o(rs1_data),
        .rs2_data_o(rs2_data),
        .we_i      (rf_we),
        .waddr_i   (rd_idx),
        .wdata_i   (rf_wdata)
    );

    assign sum    = {1'b0, rs1_data} + {1'b0, rs2_data};
    assign pc_adv = (pc_q == PC_W'(PROG_LEN - 1)) ? '0 : pc_q + 1'b1;

    // NOTE: every output of this block is given a default first, so no path
    // through the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        carry_d  = carry_q;
        rf_we    = 1'b0;
        rf_wdata = sum[DATA_W-1:0];
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;

        unique case (state_q)
            ST_FETCH: begin
                // The first cycle out of reset issues no request.
                imem_req = !boot_q;
                if (!boot_q && imem_valid) begin
                    ir_d    = imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                unique case (op)
                    OP_ADD: begin
                        rf_we   = 1'b1;
                        carry_d = sum[DATA_W];
                        pc_d    = pc_adv;
                        state_d = ST_FETCH;
                    end
                    OP_LOAD, OP_STORE: state_d = ST_MEM;
                    default:           state_d = ST_HALT;
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op == OP_STORE);
                if (dmem_ready) begin
                    if (op == OP_LOAD) begin
                        rf_we    = 1'b1;
                        rf_wdata = dmem_rdata;
                    end
                    pc_d    = pc_adv;
                    state_d = ST_FETCH;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            carry_q <= 1'b0;
            boot_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            carry_q <= carry_d;
            boot_q  <= 1'b0;
        end
    end

    assign imem_addr  = pc_q;
    assign dmem_addr  = rs1_data[DMEM_AW-1:0];
    assign dmem_wdata = rs2_data;
    assign pc         = pc_q;
    assign carry      = carry_q;
    assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_simple_core_mc.sv
// Self-checking bench for simple_core_mc: a bench-side memory responder with
// programmable wait states, and an instruction-level reference model.
`timescale 1ns/1ps
module tb_simple_core_mc;

    localparam int DATA_W   = 8;
    localparam int REG_AW   = 2;
    localparam int PC_W     = 4;
    localparam int PROG_LEN = 6;
    localparam int DMEM_AW  = 4;
    localparam int IW       = 2 + 3 * REG_AW;
    localparam int NMEM     = 2 ** DMEM_AW;

    logic                clk;
    logic                rst;
    logic                imem_req;
    logic [PC_W-1:0]     imem_addr;
    logic [IW-1:0]       imem_rdata;
    logic                imem_valid;
    logic                dmem_req;
    logic                dmem_we;
    logic [DMEM_AW-1:0]  dmem_addr;
    logic [DATA_W-1:0]   dmem_wdata;
    logic [DATA_W-1:0]   dmem_rdata;
    logic                dmem_ready;
    logic [PC_W-1:0]     pc;
    logic                carry;
    logic                halted;

    simple_core_mc #(
        .DATA_W  (DATA_W),
        .REG_AW  (REG_AW),
        .PC_W    (PC_W),
        .PROG_LEN(PROG_LEN),
        .DMEM_AW (DMEM_AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .imem_valid(imem_valid),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready),
        .pc        (pc),
        .carry     (carry),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Environment: program ROM, data memory and response timing.
    logic [IW-1:0]     prog     [PROG_LEN];
    logic [DATA_W-1:0] env_mem  [NMEM];
    logic [DATA_W-1:0] init_mem [NMEM];
    int                iwait = 0;
    int                dwait = 0;
    bit                idle_hi = 1'b0;

    bit                i_act, d_act;
    int                i_len, d_len, icnt, dcnt;
    logic [PC_W-1:0]   i_addr0;
    logic [DMEM_AW+DATA_W:0] d_snap0;

    int                fetch_pc_q  [$];
    int                fetch_cyc_q [$];
    int                wr_q        [$];

    // Reference model results.
    int                exp_pc_q  [$];
    int                exp_gap_q [$];
    int                exp_wr_q  [$];
    int                exp_pc;
    bit                exp_carry;
    bit                exp_halted;

    function automatic logic [IW-1:0] enc(input int op, input int rd, input int rs1, input int rs2);
        return IW'((op << 6) | (rd << 4) | (rs1 << 2) | rs2);
    endfunction

    // One clock: respond to the requests visible at the falling edge, then
    // advance past the rising edge and let outputs settle.
    task automatic step(input bit do_rst);
        @(negedge clk);
        rst = do_rst;
        if (imem_req === 1'b1) begin
            if (!i_act) begin
                i_act = 1'b1; i_len = 0; i_addr0 = imem_addr; icnt = iwait;
            end
            i_len++;
            checks++;
            if (imem_addr !== i_addr0) begin
                errors++; $display("FAIL imem_addr_stable: got %0d required %0d", imem_addr, i_addr0);
            end
            if (icnt == 0) begin
                imem_valid = 1'b1;
                imem_rdata = (int'(imem_addr) < PROG_LEN) ? prog[imem_addr] : enc(3, 0, 0, 0);
                checks++;
                if (i_len != iwait + 1) begin
                    errors++; $display("FAIL imem_req_len: got %0d required %0d", i_len, iwait + 1);
                end
                if (!do_rst) begin
                    fetch_pc_q.push_back(int'(imem_addr));
                    fetch_cyc_q.push_back(cyc);
                end
                i_act = 1'b0;
            end else begin
                imem_valid = 1'b0;
                imem_rdata = IW'($urandom);
                icnt--;
            end
        end else begin
            i_act      = 1'b0;
            imem_valid = idle_hi | 1'($urandom_range(0, 1));
            imem_rdata = IW'($urandom);
        end

        if (dmem_req === 1'b1) begin
            if (!d_act) begin
                d_act = 1'b1; d_len = 0; d_snap0 = {dmem_we, dmem_addr, dmem_wdata}; dcnt = dwait;
            end
            d_len++;
            checks++;
            if ({dmem_we, dmem_addr, dmem_wdata} !== d_snap0) begin
                errors++; $display("FAIL dmem_stable: got %h required %h", {dmem_we, dmem_addr, dmem_wdata}, d_snap0);
            end
            if (dcnt == 0) begin
                dmem_ready = 1'b1;
                checks++;
                if (d_len != dwait + 1) begin
                    errors++; $display("FAIL dmem_req_len: got %0d required %0d", d_len, dwait + 1);
                end
                if (dmem_we === 1'b1) begin
                    dmem_rdata = DATA_W'($urandom);
                    if (!do_rst) begin
                        wr_q.push_back((int'(dmem_addr) << 8) | int'(dmem_wdata));
                        env_mem[dmem_addr] = dmem_wdata;
                    end
                end else begin
                    dmem_rdata = env_mem[dmem_addr];
                end
                d_act = 1'b0;
            end else begin
                dmem_ready = 1'b0;
                dmem_rdata = DATA_W'($urandom);
                dcnt--;
            end
        end else begin
            d_act      = 1'b0;
            dmem_ready = idle_hi | 1'($urandom_range(0, 1));
            dmem_rdata = DATA_W'($urandom);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic reset_core();
        fetch_pc_q.delete();
        fetch_cyc_q.delete();
        wr_q.delete();
        i_act = 1'b0;
        d_act = 1'b0;
        step(1'b1);
    endtask

    // Instruction-level model: architectural effect of each instruction plus
    // its cycle cost (fetch + execute, plus memory access and wait states).
    task automatic iss(input int max_instr);
        int r [4];
        int mem [NMEM];
        int p, ins, op, rd, s1, s2, s;
        bit c;
        exp_pc_q.delete(); exp_gap_q.delete(); exp_wr_q.delete();
        for (int i = 0; i < 4; i++) r[i] = 0;
        for (int i = 0; i < NMEM; i++) mem[i] = int'(init_mem[i]);
        p = 0; c = 1'b0; exp_halted = 1'b0;
        for (int n = 0; n < max_instr; n++) begin
            ins = int'(prog[p]);
            op  = (ins >> 6) & 3; rd = (ins >> 4) & 3; s1 = (ins >> 2) & 3; s2 = ins & 3;
            exp_pc_q.push_back(p);
            if (op == 3) begin
                exp_halted = 1'b1;
                break;
            end
            if (op == 0) begin
                s     = r[s1] + r[s2];
                c     = (s > 255);
                r[rd] = s % 256;
                exp_gap_q.push_back(2 + iwait);
            end else if (op == 1) begin
                r[rd] = mem[r[s1] % NMEM];
                exp_gap_q.push_back(3 + dwait + iwait);
            end else begin
                mem[r[s1] % NMEM] = r[s2];
                exp_wr_q.push_back(((r[s1] % NMEM) << 8) | r[s2]);
                exp_gap_q.push_back(3 + dwait + iwait);
            end
            p = (p + 1) % PROG_LEN;
        end
        exp_pc    = p;
        exp_carry = c;
    endtask

    task automatic run_until(input bit want_halt, input int n_fetch, input int budget);
        int k;
        k = 0;
        while (k < budget && !(want_halt ? (halted === 1'b1) : (fetch_pc_q.size() >= n_fetch))) begin
            step(1'b0);
            k++;
        end
        checks++;
        if (k >= budget) begin
            errors++; $display("FAIL run_timeout: got %0d cycles required completion within %0d", k, budget);
        end
    endtask

    task automatic compare_run(input string tag);
        checks++;
        if (fetch_pc_q.size() < exp_pc_q.size()) begin
            errors++; $display("FAIL %s fetch_count: got %0d required %0d", tag, fetch_pc_q.size(), exp_pc_q.size());
        end
        for (int k = 0; k < exp_pc_q.size() && k < fetch_pc_q.size(); k++) begin
            checks++;
            if (fetch_pc_q[k] != exp_pc_q[k]) begin
                errors++; $display("FAIL %s fetch_pc[%0d]: got %0d required %0d", tag, k, fetch_pc_q[k], exp_pc_q[k]);
            end
        end
        for (int k = 0; k < exp_gap_q.size() && k + 1 < fetch_cyc_q.size(); k++) begin
            checks++;
            if (fetch_cyc_q[k+1] - fetch_cyc_q[k] != exp_gap_q[k]) begin
                errors++; $display("FAIL %s latency[%0d]: got %0d required %0d", tag, k, fetch_cyc_q[k+1] - fetch_cyc_q[k], exp_gap_q[k]);
            end
        end
        checks++;
        if (wr_q.size() != exp_wr_q.size()) begin
            errors++; $display("FAIL %s store_count: got %0d required %0d", tag, wr_q.size(), exp_wr_q.size());
        end
        for (int k = 0; k < exp_wr_q.size() && k < wr_q.size(); k++) begin
            checks++;
            if (wr_q[k] != exp_wr_q[k]) begin
                errors++; $display("FAIL %s store[%0d]: got %h required %h", tag, k, wr_q[k], exp_wr_q[k]);
            end
        end
        checks++;
        if ({halted, carry, pc} !== {exp_halted, exp_carry, PC_W'(exp_pc)}) begin
            errors++; $display("FAIL %s halted_carry_pc: got %b/%b/%0d required %b/%b/%0d",
                               tag, halted, carry, pc, exp_halted, exp_carry, exp_pc);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < PROG_LEN; i++) prog[i] = enc(3, 0, 0, 0);
        reset_core();
        checks++;
        if ({imem_req, dmem_req, dmem_we} !== 3'b000) begin
            errors++; $display("FAIL reset_requests: got %b required 000", {imem_req, dmem_req, dmem_we});
        end
        checks++;
        if ({halted, carry, pc} !== {1'b0, 1'b0, PC_W'(0)}) begin
            errors++; $display("FAIL reset_status: got %b/%b/%0d required 0/0/0", halted, carry, pc);
        end
        step(1'b0);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, PC_W'(0)}) begin
            errors++; $display("FAIL reset_first_fetch: got %b/%0d required 1/0", imem_req, imem_addr);
        end
    endtask

    task automatic test_program();
        iwait = 0; dwait = 0;
        prog[0] = enc(1, 1, 0, 0);
        prog[1] = enc(1, 2, 3, 0);
        prog[2] = enc(0, 0, 1, 2);
        prog[3] = enc(2, 0, 3, 0);
        prog[4] = enc(3, 0, 0, 0);
        prog[5] = enc(0, 0, 0, 0);
        for (int i = 0; i < NMEM; i++) init_mem[i] = DATA_W'($urandom);
        init_mem[0] = 8'h05;
        env_mem = init_mem;
        reset_core();
        iss(100);
        run_until(1'b1, 0, 200);
        compare_run("program");
        checks++;
        if (wr_q.size() != 1 || wr_q[0] != 32'h00A) begin
            errors++; $display("FAIL program_store: got %0d writes, first %h required 1 write 00a",
                               wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : -1);
        end
        checks++;
        if ({halted, carry, pc} !== {1'b1, 1'b0, PC_W'(4)}) begin
            errors++; $display("FAIL program_final: got %b/%b/%0d required 1/0/4", halted, carry, pc);
        end
    endtask

    task automatic test_overflow();
        iwait = 0; dwait = 0;
        prog[0] = enc(1, 3, 0, 0);
        prog[1] = enc(1, 1, 3, 0);
        prog[2] = enc(0, 3, 3, 3);
        prog[3] = enc(1, 2, 3, 0);
        prog[4] = enc(0, 3, 1, 2);
        prog[5] = enc(2, 0, 0, 3);
        for (int i = 0; i < NMEM; i++) init_mem[i] = DATA_W'($urandom);
        init_mem[0] = 8'h01; init_mem[1] = 8'hF0; init_mem[2] = 8'h20;
        env_mem = init_mem;
        reset_core();
        iss(7);
        run_until(1'b0, 8, 300);
        compare_run("overflow");
        checks++;
        if (wr_q.size() != 1 || wr_q[0] != 32'h010 || carry !== 1'b1) begin
            errors++; $display("FAIL overflow_sum_carry: got %0d writes, first %h, carry %b required 010 carry 1",
                               wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : -1, carry);
        end
    endtask

    task automatic test_pc_wrap();
        iwait = 0; dwait = 0;
        for (int i = 0; i < PROG_LEN; i++)
            prog[i] = enc(0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        init_mem = env_mem;
        reset_core();
        iss(7);
        run_until(1'b0, 8, 100);
        compare_run("pc_wrap");
        checks++;
        if (fetch_pc_q.size() < 7 || fetch_pc_q[6] != 0) begin
            errors++; $display("FAIL pc_wrap_to_zero: got %0d required 0", (fetch_pc_q.size() >= 7) ? fetch_pc_q[6] : -1);
        end
    endtask

    task automatic test_wait_states();
        iwait = 3; dwait = 2;
        prog[0] = enc(1, 1, 0, 0);
        prog[1] = enc(2, 0, 2, 1);
        prog[2] = enc(0, 2, 1, 1);
        prog[3] = enc(2, 0, 1, 2);
        prog[4] = enc(1, 3, 1, 0);
        prog[5] = enc(3, 0, 0, 0);
        for (int i = 0; i < NMEM; i++) init_mem[i] = DATA_W'($urandom);
        env_mem = init_mem;
        reset_core();
        iss(100);
        run_until(1'b1, 0, 300);
        compare_run("wait_states");
    endtask

    task automatic test_reset_mid_mem();
        int k;
        iwait = 0; dwait = 0;
        prog[0] = enc(1, 1, 0, 0);
        prog[1] = enc(0, 2, 1, 1);
        prog[2] = enc(2, 0, 0, 2);
        prog[3] = enc(3, 0, 0, 0);
        prog[4] = enc(3, 0, 0, 0);
        prog[5] = enc(3, 0, 0, 0);
        env_mem[0] = 8'h33;
        reset_core();
        run_until(1'b0, 3, 100);
        dwait = 10;
        k = 0;
        while (dmem_req !== 1'b1 && k < 20) begin
            step(1'b0);
            k++;
        end
        checks++;
        if (dmem_req !== 1'b1) begin
            errors++; $display("FAIL mid_mem_reach: got dmem_req %b required 1", dmem_req);
        end
        idle_hi = 1'b1;
        reset_core();
        checks++;
        if ({dmem_req, dmem_we, imem_req, pc} !== {3'b000, PC_W'(0)}) begin
            errors++; $display("FAIL mid_mem_reset: got %b/%b/%b/%0d required 0/0/0/0", dmem_req, dmem_we, imem_req, pc);
        end
        // Registers must be zero again: store r1..r3 to address r0.
        prog[0] = enc(2, 0, 0, 1);
        prog[1] = enc(2, 0, 0, 2);
        prog[2] = enc(2, 0, 0, 3);
        prog[3] = enc(3, 0, 0, 0);
        dwait = 0;
        step(1'b0);
        idle_hi = 1'b0;
        init_mem = env_mem;
        iss(100);
        run_until(1'b1, 0, 200);
        compare_run("mid_mem_reset");
    endtask

    task automatic test_halt();
        // Continues from the halted core left by the previous scenario.
        for (int n = 0; n < 20; n++) begin
            idle_hi = 1'($urandom_range(0, 1));
            step(1'b0);
            checks++;
            if ({imem_req, dmem_req, halted, pc} !== {3'b001, PC_W'(exp_pc)}) begin
                errors++; $display("FAIL halt_hold[%0d]: got %b/%b/%b/%0d required 0/0/1/%0d",
                                   n, imem_req, dmem_req, halted, pc, exp_pc);
            end
        end
        idle_hi = 1'b0;
        reset_core();
        checks++;
        if ({halted, pc} !== {1'b0, PC_W'(0)}) begin
            errors++; $display("FAIL halt_exit: got %b/%0d required 0/0", halted, pc);
        end
        step(1'b0);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, PC_W'(0)}) begin
            errors++; $display("FAIL halt_refetch: got %b/%0d required 1/0", imem_req, imem_addr);
        end
    endtask

    task automatic test_random();
        int h;
        for (int it = 0; it < 25; it++) begin
            iwait = $urandom_range(0, 2);
            dwait = $urandom_range(0, 2);
            h = $urandom_range(2, PROG_LEN - 1);
            for (int i = 0; i < PROG_LEN; i++)
                prog[i] = enc($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            prog[h] = enc(3, 0, 0, 0);
            for (int i = 0; i < NMEM; i++) init_mem[i] = DATA_W'($urandom);
            env_mem = init_mem;
            reset_core();
            iss(100);
            run_until(1'b1, 0, 400);
            compare_run("random");
        end
    endtask

    initial begin
        rst        = 1'b1;
        imem_valid = 1'b0;
        imem_rdata = '0;
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        for (int i = 0; i < NMEM; i++) env_mem[i] = '0;
        test_reset();
        test_program();
        test_overflow();
        test_pc_wrap();
        test_wait_states();
        test_reset_mid_mem();
        test_halt();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
